// File: rtl/reg_bank_arbiter.sv
// Two-port round-robin arbiter in front of a bank of load-enable 16-bit registers, with zero-fill sequencing.
// Latency: a write is visible to a read granted in the next cycle; read data/rvalid appear one cycle after the grant.
// Backpressure: ready is withheld during zero-fill, on a clear request, and from the losing port of a conflict; responses cannot be stalled.

// Single register cell: load-enable storage with no reset, contents undefined until written.
// Latency: q reflects d from the cycle after load is asserted.
// Backpressure: none; loads whenever load is high.
module reg_cell #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d on any cycle the cell is selected for writing.
  always_ff @(posedge clk) begin
    if (load) q <= d;
  end

endmodule

module reg_bank_arbiter #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int WIDTH    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,

  input  logic              a_valid,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [WIDTH-1:0]  a_wdata,
  output logic              a_ready,
  output logic              a_rvalid,
  output logic [WIDTH-1:0]  a_rdata,

  input  logic              b_valid,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [WIDTH-1:0]  b_wdata,
  output logic              b_ready,
  output logic              b_rvalid,
  output logic [WIDTH-1:0]  b_rdata
);

  typedef enum logic {
    CLEAR = 1'b0,
    ARB   = 1'b1
  } state_t;

  // prio: 0 means port A wins the next conflict, 1 means port B wins.
  localparam logic PRIO_A = 1'b0;
  localparam logic PRIO_B = 1'b1;

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic              prio;

  logic              arb_open;
  logic              bank_we;
  logic [ADDR_W-1:0] bank_addr;
  logic [WIDTH-1:0]  bank_wdata;
  logic [WIDTH-1:0]  bank_rdata;
  logic              rd_a;
  logic              rd_b;
  logic [WIDTH-1:0]  cell_q [NUM_REGS];

  // busy comes straight from the state flop, so it is glitch-free and high out of reset.
  assign busy = (state == CLEAR);

  // Grant decision: only in ARB, and a clear request suppresses every grant in its cycle.
  always_comb begin
    arb_open = (state == ARB) && !clr_req;
    a_ready  = arb_open && a_valid && (!b_valid || (prio == PRIO_A));
    b_ready  = arb_open && b_valid && (!a_valid || (prio == PRIO_B));
  end

  // Single bank port: zero-fill owns it during CLEAR, otherwise the granted requester drives it.
  always_comb begin
    bank_we    = 1'b0;
    bank_addr  = '0;
    bank_wdata = '0;
    if (state == CLEAR) begin
      bank_we   = 1'b1;
      bank_addr = clr_ptr;
    end else if (a_ready) begin
      bank_we    = a_we;
      bank_addr  = a_addr;
      bank_wdata = a_wdata;
    end else if (b_ready) begin
      bank_we    = b_we;
      bank_addr  = b_addr;
      bank_wdata = b_wdata;
    end
  end

  assign rd_a = a_ready && !a_we;
  assign rd_b = b_ready && !b_we;

  // One register cell per address, each loaded only when the bank port targets it.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_bank
    reg_cell #(.WIDTH(WIDTH)) u_cell (
      .clk  (clk),
      .load (bank_we && (bank_addr == ADDR_W'(i))),
      .d    (bank_wdata),
      .q    (cell_q[i])
    );
  end

  assign bank_rdata = cell_q[bank_addr];

  // Controller: zero-fill walk, clear-request capture, and round-robin priority tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      prio    <= PRIO_A;
    end else begin
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + ADDR_W'(1);
          if (clr_ptr == ADDR_W'(NUM_REGS - 1)) state <= ARB;
        end
        ARB: begin
          if (clr_req) begin
            state   <= CLEAR;
            clr_ptr <= '0;
          end else if (a_ready) begin
            prio <= PRIO_B;
          end else if (b_ready) begin
            prio <= PRIO_A;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Port A read response: one-cycle rvalid, rdata holds between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid <= 1'b0;
      a_rdata  <= '0;
    end else begin
      a_rvalid <= rd_a;
      if (rd_a) a_rdata <= bank_rdata;
    end
  end

  // Port B read response: one-cycle rvalid, rdata holds between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_rvalid <= 1'b0;
      b_rdata  <= '0;
    end else begin
      b_rvalid <= rd_b;
      if (rd_b) b_rdata <= bank_rdata;
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Bench for reg_bank_arbiter: directed scenarios with literal expectations, then randomized traffic.
// A behavioural model tracks bank contents, clear progress, priority and pending read responses.
// Outputs are compared against the model on every falling edge.
module tb_reg_bank_arbiter;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr_req = 1'b0;
  logic        busy;
  logic        a_valid = 1'b0, a_we = 1'b0;
  logic [2:0]  a_addr = '0;
  logic [15:0] a_wdata = '0;
  logic        a_ready, a_rvalid;
  logic [15:0] a_rdata;
  logic        b_valid = 1'b0, b_we = 1'b0;
  logic [2:0]  b_addr = '0;
  logic [15:0] b_wdata = '0;
  logic        b_ready, b_rvalid;
  logic [15:0] b_rdata;

  int checks = 0;
  int errors = 0;

  reg_bank_arbiter #(.NUM_REGS(N), .ADDR_W(3), .WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy),
    .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] mem [N];
  int          m_clear_left = N;   // cycles of zero-fill still to run
  bit          m_b_next = 1'b0;    // port B wins the next conflict
  bit          m_pa = 0, m_pb = 0; // read response due this cycle
  logic [15:0] m_ra = '0, m_rb = '0;
  bit          m_ga = 0, m_gb = 0; // grants issued in the previous cycle

  // Compare DUT against model, then advance model by one cycle.
  always @(negedge clk) begin
    bit e_busy, open, ga, gb;
    if (!rst_n) begin
      chk("rst_busy", busy, 1);
      chk("rst_a_ready", a_ready, 0);
      chk("rst_b_ready", b_ready, 0);
      chk("rst_a_rvalid", a_rvalid, 0);
      chk("rst_b_rvalid", b_rvalid, 0);
      chk("rst_a_rdata", a_rdata, 0);
      chk("rst_b_rdata", b_rdata, 0);
      m_clear_left = N; m_b_next = 0;
      m_pa = 0; m_pb = 0; m_ra = '0; m_rb = '0; m_ga = 0; m_gb = 0;
    end else begin
      e_busy = (m_clear_left != 0);
      open   = !e_busy && !clr_req;
      ga     = open && a_valid && (!b_valid || !m_b_next);
      gb     = open && b_valid && (!a_valid || m_b_next);
      chk("busy", busy, e_busy);
      chk("a_ready", a_ready, ga);
      chk("b_ready", b_ready, gb);
      chk("a_rvalid", a_rvalid, m_pa);
      chk("b_rvalid", b_rvalid, m_pb);
      chk("a_rdata", a_rdata, m_ra);
      chk("b_rdata", b_rdata, m_rb);
      m_pa = 0; m_pb = 0;
      if (e_busy) begin
        mem[N - m_clear_left] = 16'h0000;
        m_clear_left--;
      end else if (clr_req) begin
        m_clear_left = N;
      end else if (ga) begin
        if (a_we) mem[a_addr] = a_wdata;
        else begin m_pa = 1; m_ra = mem[a_addr]; end
        m_b_next = 1;
      end else if (gb) begin
        if (b_we) mem[b_addr] = b_wdata;
        else begin m_pb = 1; m_rb = mem[b_addr]; end
        m_b_next = 0;
      end
      m_ga = ga; m_gb = gb;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_a(input bit v, input bit we, input int addr, input logic [15:0] d);
    a_valid = v; a_we = we; a_addr = addr[2:0]; a_wdata = d;
  endtask

  task automatic set_b(input bit v, input bit we, input int addr, input logic [15:0] d);
    b_valid = v; b_we = we; b_addr = addr[2:0]; b_wdata = d;
  endtask

  task automatic next;
    @(posedge clk); #1;
  endtask

  task automatic samp;
    @(negedge clk);
  endtask

  // Counts busy cycles over a 10-cycle window starting at the current cycle.
  task automatic count_busy(input string nm);
    int bc = 0;
    for (int c = 0; c < 10; c++) begin
      samp;
      if (busy) bc++;
      next;
    end
    chk(nm, bc, 8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, time 0x%0h required below 0x%0h", $time, 200000);
    $fatal(1);
  end

  initial begin
    int na;
    bit prev_a, gotb, seen;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    count_busy("busy_after_reset");

    // A reads every address after the zero-fill
    for (int i = 0; i < N; i++) begin
      set_a(1, 0, i, 16'h0);
      next;
    end
    set_a(0, 0, 0, 16'h0);
    samp;
    chk("fill_rvalid", a_rvalid, 1);
    chk("fill_rdata7", a_rdata, 16'h0000);
    next;

    // write then immediately read back
    set_a(1, 1, 3, 16'hBEEF);
    next;
    set_a(1, 0, 3, 16'h0);
    next;
    set_a(0, 0, 0, 16'h0);
    samp;
    chk("wr_rd_rvalid", a_rvalid, 1);
    chk("wr_rd_rdata", a_rdata, 16'hBEEF);
    chk("wr_rd_b_rvalid", b_rvalid, 0);
    next;

    // both requesters reading continuously alternate
    set_a(1, 0, 1, 16'h0);
    set_b(1, 0, 2, 16'h0);
    na = 0; prev_a = 0;
    for (int k = 0; k < 6; k++) begin
      samp;
      chk("alt_onehot", a_ready ^ b_ready, 1);
      if (k > 0) chk("alt_flip", a_ready, !prev_a);
      prev_a = a_ready;
      if (a_ready) na++;
      next;
    end
    chk("alt_a_count", na, 3);
    set_a(0, 0, 0, 16'h0);
    set_b(0, 0, 0, 16'h0);
    next;

    // clear request wipes earlier write and blocks the concurrent request
    set_a(1, 1, 5, 16'h1234);
    next;
    set_a(0, 0, 0, 16'h0);
    set_b(1, 0, 5, 16'h0);
    clr_req = 1'b1;
    samp;
    chk("clr_b_ready", b_ready, 0);
    next;
    clr_req = 1'b0;
    gotb = 0; seen = 0;
    for (int c = 0; c < 10; c++) begin
      samp;
      if (c < 8) chk("clr_busy", busy, 1);
      if (b_ready) gotb = 1;
      if (b_rvalid) begin seen = 1; chk("clr_rd5", b_rdata, 16'h0000); end
      next;
      if (gotb) set_b(0, 0, 0, 16'h0);
    end
    chk("clr_rd_seen", seen, 1);

    // reset lands while a read grant is in flight
    set_a(1, 0, 3, 16'h0);
    samp;
    chk("rst_grant", a_ready, 1);
    #1 rst_n = 1'b0;
    set_a(0, 0, 0, 16'h0);
    for (int c = 0; c < 3; c++) begin
      samp;
      chk("rst_mid_rvalid", a_rvalid, 0);
      chk("rst_mid_busy", busy, 1);
      next;
    end
    rst_n = 1'b1;
    count_busy("busy_after_rerst");

    // B alone three times, then A wins the conflict
    set_b(1, 0, 6, 16'h0);
    for (int k = 0; k < 3; k++) begin
      samp;
      chk("b_alone", b_ready, 1);
      next;
    end
    set_a(1, 0, 0, 16'h0);
    samp;
    chk("conf_a_ready", a_ready, 1);
    chk("conf_b_ready", b_ready, 0);
    next;
    set_a(0, 0, 0, 16'h0);
    set_b(0, 0, 0, 16'h0);
    next;

    // randomized traffic; requests are held until the model says they were granted
    for (int n = 0; n < 3000; n++) begin
      if (!a_valid || m_ga) begin
        if ($urandom_range(0, 9) < 6) set_a(1, $urandom_range(0, 1), $urandom_range(0, N - 1), 16'($urandom));
        else set_a(0, 0, 0, 16'h0);
      end
      if (!b_valid || m_gb) begin
        if ($urandom_range(0, 9) < 6) set_b(1, $urandom_range(0, 1), $urandom_range(0, N - 1), 16'($urandom));
        else set_b(0, 0, 0, 16'h0);
      end
      clr_req = ($urandom_range(0, 63) == 0);
      next;
    end
    set_a(0, 0, 0, 16'h0);
    set_b(0, 0, 0, 16'h0);
    clr_req = 1'b0;
    repeat (3) next;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
